// File: rtl/axis_drop_ctrl.sv
// Per-port congestion controller: raises drop after a sustained downstream stall and
// releases it after sustained readiness plus a minimum hold. Optional event counters: AXIS_DROP_CTRL_EVENT_CNT_EN.
module axis_drop_ctrl #(
   parameter int PORT_COUNT    = 4,
   parameter int STALL_LIMIT   = 64,
   parameter int HOLD_CYCLES   = 256,
   parameter int READY_LIMIT   = 16,
   parameter int EVT_CNT_WIDTH = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [PORT_COUNT-1:0]               enable,
   input  logic [PORT_COUNT-1:0]               mon_tvalid,
   input  logic [PORT_COUNT-1:0]               mon_tready,
   output logic [PORT_COUNT-1:0]               drop,
   output logic [PORT_COUNT*EVT_CNT_WIDTH-1:0] drop_events
);
   // state | meaning
   // PASS  | traffic flows; counting consecutive stall cycles
   // DROP  | drop requested; counting hold time and consecutive ready cycles

   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(READY_LIMIT + 1);

   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
   localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
   localparam logic [RW-1:0] READY_MAX  = RW'(READY_LIMIT);

   typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

   for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
      state_t        state;
      logic [SW-1:0] stall_cnt;
      logic [HW-1:0] hold_cnt;
      logic [RW-1:0] ready_cnt;
      logic          stall;
      logic          enter;

      assign stall = mon_tvalid[i] & ~mon_tready[i];
      // Gated by enable so a same-cycle disable suppresses both the entry and its event.
      assign enter = enable[i] && (state == PASS) && stall && (stall_cnt == STALL_LAST);

      always_ff @(posedge clk) begin
         if (rst || !enable[i]) begin
            state     <= PASS;
            stall_cnt <= '0;
            hold_cnt  <= '0;
            ready_cnt <= '0;
         end else begin
            case (state)
               PASS: begin
                  if (enter) begin
                     state     <= DROP;
                     stall_cnt <= '0;
                     hold_cnt  <= '0;
                     ready_cnt <= '0;
                  end else if (stall) begin
                     if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
                  end else begin
                     stall_cnt <= '0;
                  end
               end
               DROP: begin
                  if (hold_cnt == HOLD_MAX && ready_cnt == READY_MAX) begin
                     state     <= PASS;
                     stall_cnt <= '0;
                     hold_cnt  <= '0;
                     ready_cnt <= '0;
                  end else begin
                     if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                     if (!mon_tready[i])            ready_cnt <= '0;
                     else if (ready_cnt != READY_MAX) ready_cnt <= ready_cnt + 1'b1;
                  end
               end
               default: state <= PASS;
            endcase
         end
      end

      assign drop[i] = (state == DROP);

`ifdef AXIS_DROP_CTRL_EVENT_CNT_EN
      logic [EVT_CNT_WIDTH-1:0] evt_cnt;

      // Held across enable deassertion; only reset clears it.
      always_ff @(posedge clk) begin
         if (rst)                        evt_cnt <= '0;
         else if (enter && evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;
      end

      assign drop_events[i*EVT_CNT_WIDTH +: EVT_CNT_WIDTH] = evt_cnt;
`else
      assign drop_events[i*EVT_CNT_WIDTH +: EVT_CNT_WIDTH] = '0;
`endif
   end

endmodule

// File: tb/tb_axis_drop_ctrl.sv
// Bench for axis_drop_ctrl: per-cycle comparison against a run-length model plus
// directed literal checks (STALL_LIMIT=4, HOLD_CYCLES=8, READY_LIMIT=2, EVT_CNT_WIDTH=2).
module tb_axis_drop_ctrl;
   localparam int P = 4;
   localparam int S = 4;
   localparam int H = 8;
   localparam int R = 2;
   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [P-1:0]   enable = '1;
   logic [P-1:0]   mon_tvalid = '0;
   logic [P-1:0]   mon_tready = '1;
   logic [P-1:0]   drop;
   logic [P*W-1:0] drop_events;

   int checks = 0;
   int errors = 0;
   bit live = 1'b0;

   axis_drop_ctrl #(
      .PORT_COUNT(P), .STALL_LIMIT(S), .HOLD_CYCLES(H),
      .READY_LIMIT(R), .EVT_CNT_WIDTH(W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mon_tvalid(mon_tvalid),
      .mon_tready(mon_tready), .drop(drop), .drop_events(drop_events)
   );

   always #5 clk = ~clk;

   // Model: unbounded run lengths; dropping is entered when a stall extends a run of
   // S-1 stalls, and left once it has lasted H cycles and seen R ready cycles in a row.
   bit m_drop [P];
   int m_run  [P];
   int m_age  [P];
   int m_rdy  [P];
   int m_ev   [P];

   always @(posedge clk) begin
      live <= 1'b1;
      for (int p = 0; p < P; p++) begin
         if (rst) begin
            m_drop[p] = 0; m_run[p] = 0; m_age[p] = 0; m_rdy[p] = 0; m_ev[p] = 0;
         end else if (!enable[p]) begin
            m_drop[p] = 0; m_run[p] = 0; m_age[p] = 0; m_rdy[p] = 0;
         end else if (!m_drop[p]) begin
            if (mon_tvalid[p] && !mon_tready[p]) begin
               if (m_run[p] + 1 >= S) begin
                  m_drop[p] = 1; m_run[p] = 0; m_age[p] = 0; m_rdy[p] = 0;
                  if (m_ev[p] < (1 << W) - 1) m_ev[p]++;
               end else m_run[p]++;
            end else m_run[p] = 0;
         end else begin
            if (m_age[p] >= H && m_rdy[p] >= R) begin
               m_drop[p] = 0; m_age[p] = 0; m_rdy[p] = 0;
            end else begin
               m_age[p]++;
               m_rdy[p] = mon_tready[p] ? m_rdy[p] + 1 : 0;
            end
         end
      end
   end

   function automatic int exp_ev(int p);
`ifdef AXIS_DROP_CTRL_EVENT_CNT_EN
      return m_ev[p];
`else
      return 0;
`endif
   endfunction

   always @(negedge clk) begin
      if (live) begin
         for (int p = 0; p < P; p++) begin
            checks++;
            if (drop[p] !== m_drop[p]) begin
               errors++;
               $display("FAIL model_drop port %0d t=%0t got %b want %b", p, $time, drop[p], m_drop[p]);
            end
            checks++;
            if (drop_events[p*W +: W] !== W'(exp_ev(p))) begin
               errors++;
               $display("FAIL model_events port %0d t=%0t got %0d want %0d", p, $time,
                        drop_events[p*W +: W], exp_ev(p));
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int ev(int p);
      return int'(drop_events[p*W +: W]);
   endfunction

`ifdef AXIS_DROP_CTRL_EVENT_CNT_EN
   localparam bit CNT = 1'b1;
`else
   localparam bit CNT = 1'b0;
`endif

   int n;

   initial begin
      step(2);
      rst = 1'b0;
      chk("reset_drop", int'(drop), 0);
      chk("reset_events", int'(drop_events), 0);

      // Detection latency on port 0
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b0;
      step(3);
      chk("detect_cycle3", int'(drop), 0);
      step(1);
      chk("detect_cycle4", int'(drop), 4'b0001);
      chk("detect_events0", ev(0), CNT ? 1 : 0);

      // Continuous ready from entry: high H+1 cycles
      mon_tvalid[0] = 1'b0; mon_tready[0] = 1'b1;
      n = 0;
      while (drop[0] && n < 100) begin n++; step(); end
      chk("release_len", n, 9);

      // Ready gap in 7th DROP cycle delays release by one
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b0;
      step(4);
      mon_tvalid[0] = 1'b0;
      n = 0;
      while (drop[0] && n < 100) begin
         mon_tready[0] = (n == 6) ? 1'b0 : 1'b1;
         n++;
         step();
      end
      mon_tready[0] = 1'b1;
      chk("release_gap_len", n, 10);
      chk("events0_two", ev(0), CNT ? 2 : 0);

      // Stall broken by a transfer never triggers
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b0; step(3);
      mon_tready[0] = 1'b1; step(1);
      mon_tready[0] = 1'b0; step(3);
      chk("broken_stall", int'(drop), 0);
      mon_tvalid[0] = 1'b0; mon_tready[0] = 1'b1; step(2);
      chk("broken_stall_after", int'(drop), 0);

      // Disable during DROP on port 1
      mon_tvalid[1] = 1'b1; mon_tready[1] = 1'b0; step(4);
      chk("en_drop_up", int'(drop), 4'b0010);
      step(2);
      enable[1] = 1'b0; step(1);
      chk("en_drop_off", int'(drop[1]), 0);
      chk("en_events_held", ev(1), CNT ? 1 : 0);
      enable[1] = 1'b1; step(3);
      chk("en_cleared", int'(drop[1]), 0);
      // Disable coinciding with the entry condition wins
      enable[1] = 1'b0; step(1);
      enable[1] = 1'b1;
      chk("en_wins_drop", int'(drop[1]), 0);
      chk("en_wins_events", ev(1), CNT ? 1 : 0);
      mon_tvalid[1] = 1'b0; mon_tready[1] = 1'b1; step(2);

      // Ports 0 and 3 together, released independently
      mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b0;
      mon_tvalid[3] = 1'b1; mon_tready[3] = 1'b0;
      step(4);
      chk("multi_up", int'(drop), 4'b1001);
      mon_tvalid = '0; mon_tready[0] = 1'b1;
      step(9);
      chk("multi_p0_released", int'(drop), 4'b1000);
      mon_tready[3] = 1'b1;
      step(2);
      chk("multi_p3_held", int'(drop), 4'b1000);
      step(1);
      chk("multi_p3_released", int'(drop), 0);
      chk("multi_events3", ev(3), CNT ? 1 : 0);

      // Five episodes on port 2 saturate the 2-bit counter
      for (int e = 0; e < 5; e++) begin
         mon_tvalid[2] = 1'b1; mon_tready[2] = 1'b0; step(4);
         mon_tvalid[2] = 1'b0; mon_tready[2] = 1'b1;
         n = 0;
         while (drop[2] && n < 50) begin n++; step(); end
         chk("sat_episode_len", n, 9);
      end
      chk("sat_events2", ev(2), CNT ? 3 : 0);

      // Reset in the middle of DROP
      mon_tvalid[2] = 1'b1; mon_tready[2] = 1'b0; step(5);
      chk("midrst_up", int'(drop[2]), 1);
      rst = 1'b1; step(1);
      chk("midrst_drop", int'(drop), 0);
      chk("midrst_events", int'(drop_events), 0);
      rst = 1'b0; mon_tvalid = '0; mon_tready = '1; step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule
